// File: rtl/shared_memory_port.sv
// Shared single-port memory with a round-robin request/grant arbiter; one access commits per clock.
// Optional per-byte write enables are built when SHARED_MEMORY_BYTE_EN is defined.
module shared_memory_port #(
    parameter int CHANNELS   = 4,
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 262144
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_pause,
    input  logic [CHANNELS-1:0]              i_req,
    input  logic [CHANNELS-1:0]              i_wren,
    input  logic [CHANNELS*ADDR_WIDTH-1:0]   i_address,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   i_data_write,
`ifdef SHARED_MEMORY_BYTE_EN
    input  logic [CHANNELS*DATA_WIDTH/8-1:0] i_byte_en,
`endif
    output logic [CHANNELS-1:0]              o_grant,
    output logic [CHANNELS-1:0]              o_rd_valid,
    output logic [DATA_WIDTH-1:0]            o_data_read,
    output logic                             o_out_of_range
);

    localparam int LW = $clog2(CHANNELS);
    localparam int NB = DATA_WIDTH / 8;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [LW-1:0]         r_last_winner;
    logic [CHANNELS-1:0]   r_grant;
    logic [CHANNELS-1:0]   r_rd_valid;
    logic [DATA_WIDTH-1:0] r_data_read;
    logic                  r_out_of_range;

    logic [LW-1:0]         w_winner;
    logic [LW-1:0]         w_cand;
    logic                  w_found;
    logic                  w_commit;
    logic                  w_wren;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_in_range;
    logic [MW-1:0]         w_mem_idx;
    logic [CHANNELS-1:0]   w_onehot;
    logic [NB-1:0]         w_be;

    // Search starts one past the previous winner so every requester is served in turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_winner;
        w_cand   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            w_cand = LW'((int'(r_last_winner) + k) % CHANNELS);
            if (!w_found && i_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_commit   = w_found & ~i_pause & ~i_reset;
    assign w_wren     = i_wren[w_winner];
    assign w_addr     = i_address[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata    = i_data_write[w_winner*DATA_WIDTH +: DATA_WIDTH];
    assign w_in_range = ({1'b0, w_addr} < (ADDR_WIDTH+1)'(DEPTH));
    assign w_mem_idx  = w_addr[MW-1:0];
    assign w_onehot   = CHANNELS'(1) << w_winner;

`ifdef SHARED_MEMORY_BYTE_EN
    assign w_be = i_byte_en[w_winner*NB +: NB];
`else
    assign w_be = '1;
`endif

    // Memory array has no reset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (w_commit && w_wren && w_in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) r_mem[w_mem_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last_winner  <= LW'(CHANNELS - 1);
            r_grant        <= '0;
            r_rd_valid     <= '0;
            r_data_read    <= '0;
            r_out_of_range <= 1'b0;
        end else begin
            r_grant        <= w_commit ? w_onehot : '0;
            r_rd_valid     <= (w_commit && !w_wren) ? w_onehot : '0;
            r_out_of_range <= w_commit & ~w_in_range;
            if (w_commit) r_last_winner <= w_winner;
            if (w_commit && !w_wren) r_data_read <= w_in_range ? r_mem[w_mem_idx] : '0;
        end
    end

    assign o_grant        = r_grant;
    assign o_rd_valid     = r_rd_valid;
    assign o_data_read    = r_data_read;
    assign o_out_of_range = r_out_of_range;

endmodule
